register_file_param: RTL and testbench
======================================

// Module: register_file_param
// PURPOSE
//  - Parametrised general-purpose register file for the RISC core: 2 async read ports, 1 sync write port.
//  - Adds write-to-read bypass, optional hard-wired zero register, and a multi-cycle clear sequencer.
//  - Sits between decode (read addresses) and writeback (write port); clear is driven by core control.
// PARAMETERS
//  DATA_W    8  register width in bits
//  ADDR_W    2  address width; DEPTH = 2**ADDR_W registers
//  ZERO_REG  0  1: register 0 always reads 0 and ignores writes
//  BYPASS    1  1: a same-cycle write is forwarded to matching read ports
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high reset
//  reg_write   in   1       write enable
//  write_reg   in   ADDR_W  write address
//  write_data  in   DATA_W  write data
//  read_reg1   in   ADDR_W  read port 1 address
//  read_reg2   in   ADDR_W  read port 2 address
//  read_data1  out  DATA_W  read port 1 data (combinational)
//  read_data2  out  DATA_W  read port 2 data (combinational)
//  clr_req     in   1       start clear sequence (level sampled in IDLE)
//  clr_busy    out  1       clear in progress; writes dropped while high
//  clr_done    out  1       one-cycle pulse on the final clear cycle
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset, sampled at the clk edge: all registers <= 0, FSM -> IDLE, index <= 0, clr_busy = 0, clr_done = 0.
//    read_dataN = 0 after reset.
//  - Reads are asynchronous: read_dataN = regs[read_regN].
//    BYPASS=1 and reg_write & ~clr_busy & (write_reg==read_regN): read_dataN = write_data.
//    ZERO_REG=1 overrides both cases: address 0 reads 0.
//  - Write: registers update at the clk edge when reg_write & ~clr_busy. With ZERO_REG=1, writes to address 0 are dropped.
//  - Priority at an edge: reset > clear step > write.
//  - FSM IDLE: clr_req=1 -> CLEAR, index <= 0, clr_busy <= 1.
//  - FSM CLEAR: each cycle regs[index] <= 0, index <= index+1.
//    When index == DEPTH-1: clr_done = 1 that cycle; -> IDLE, clr_busy <= 0.
//  - Clear latency: exactly DEPTH cycles with clr_busy high. clr_done is combinational: (state==CLEAR) & (index==DEPTH-1).
//  - clr_req while in CLEAR: ignored; no restart or extension.
//  - clr_req held high: a new clear starts on the cycle after return to IDLE.
//  - Reads during CLEAR return current contents (partially cleared). Bypass is inactive while clr_busy.
//  - Index width is ADDR_W. Wrap from DEPTH-1 to 0 coincides with the exit from CLEAR.
//  - Reset mid-CLEAR: full zero, FSM -> IDLE; no clr_done pulse.
//  - Same-address simultaneous read and write with BYPASS=0: read returns the old value; the new value appears the next cycle.
// STRUCTURE
//  - Shared package/include rf_defs: FSM state encodings RF_IDLE=1'b0, RF_CLEAR=1'b1; default DATA_W/ADDR_W constants.
//  - Sub-module rf_clear_seq: FSM plus index counter.
//    Outputs clr_busy, clr_done, clr_idx, clr_we. The top level holds the array, read muxes and bypass.
// TESTING
//  1 Reset then read all addresses -> read_data1/2 = 8'h00; clr_busy=0, clr_done=0.
//  2 Write r2=8'hA5; next cycle read_reg1=2 -> 8'hA5.
//    Same cycle write r3=8'h3C with read_reg2=3: BYPASS=1 -> 8'h3C; BYPASS=0 -> old value.
//  3 ZERO_REG=1: write r0=8'hFF -> read r0 = 8'h00. Bypass of r0 also reads 8'h00.
//  4 Preload r0..r3=11,22,33,44; pulse clr_req:
//    - clr_busy high exactly 4 cycles; clr_done on the 4th.
//    - After cycle 2, r0=r1=0 and r2=33.
//    - A write of r3=77 issued during CLEAR is dropped; r3=0 after done.
//  5 ADDR_W=3: start clear, assert reset on the 3rd CLEAR cycle.
//    - All regs 0, clr_busy=0 next cycle, no clr_done.
//    - Hold clr_req high -> back-to-back clears of 8 cycles each.

Source files
------------

// File: rtl/register_file_param_pkg.sv
// Shared definitions for the register file: clear-sequencer state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package register_file_param_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W_DEF = 8;
    localparam int RF_ADDR_W_DEF = 2;

endpackage

// File: rtl/register_file_param_if.sv
// Register file access bundle: write port, two read ports and clear control/status.
// Latency: reads combinational, writes land at the next clk edge.
// Backpressure: clr_busy high means writes are dropped; no other stall.
//   master: drives reg_write/write_reg/write_data/read_reg1/read_reg2/clr_req
//   slave : drives read_data1/read_data2/clr_busy/clr_done
interface register_file_param_if
    import register_file_param_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF
);
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2, clr_req,
        input  read_data1, read_data2, clr_busy, clr_done
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2, clr_req,
        output read_data1, read_data2, clr_busy, clr_done
    );
endinterface

// File: rtl/register_file_param_rf_clear_seq.sv
// Clear sequencer: walks an index over every register, zeroing one per cycle.
// Latency: busy for exactly 2**ADDR_W cycles after clr_req is seen in IDLE; done on the last.
// Backpressure: clr_req is ignored while a clear runs; no restart or extension.
//   clk, reset     : clock and synchronous active-high reset
//   clr_req        : start request, level-sampled in IDLE
//   clr_busy/done  : in-progress flag and final-cycle pulse
//   clr_idx/clr_we : register to zero this cycle and its enable
module rf_clear_seq
    import register_file_param_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              clr_we
);
    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RF_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        clr_we    = 1'b0;
        unique case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt = RF_CLEAR;
                    idx_nxt   = '0;
                end
            end
            RF_CLEAR: begin
                clr_busy = 1'b1;
                clr_we   = 1'b1;
                // The natural wrap of idx back to 0 coincides with the exit.
                idx_nxt  = idx + 1'b1;
                if (idx == IDX_LAST) begin
                    clr_done  = 1'b1;
                    state_nxt = RF_IDLE;
                end
            end
            default: state_nxt = RF_IDLE;
        endcase
    end

    assign clr_idx = idx;
endmodule

// File: rtl/register_file_param.sv
// General-purpose register file: 2 async read ports, 1 sync write port, bypass, zero reg, clear.
// Latency: reads combinational; writes and clear steps take effect at the next clk edge.
// Backpressure: writes are silently dropped while clr_busy is high.
//   clk, reset : clock and synchronous active-high reset
//   rf         : slave side of register_file_param_if (write, reads, clear)
module register_file_param
    import register_file_param_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    register_file_param_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_idx;
    logic              clr_we;
    logic              wr_ok;
    logic              wr_en;
    logic              byp_en;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (rf.clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_idx  (clr_idx),
        .clr_we   (clr_we)
    );

    // A write is live only outside a clear; bypass follows the same qualification.
    assign wr_ok  = rf.reg_write & ~clr_busy;
    assign wr_en  = wr_ok & ~(ZERO_REG && (rf.write_reg == '0));
    assign byp_en = BYPASS && wr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (clr_we) begin
            regs[clr_idx] <= '0;
        end else if (wr_en) begin
            regs[rf.write_reg] <= rf.write_data;
        end
    end

    // Zero-register override is applied last so it beats the bypass path.
    always_comb begin
        rd1 = regs[rf.read_reg1];
        if (byp_en && (rf.write_reg == rf.read_reg1)) rd1 = rf.write_data;
        if (ZERO_REG && (rf.read_reg1 == '0))         rd1 = '0;
    end

    always_comb begin
        rd2 = regs[rf.read_reg2];
        if (byp_en && (rf.write_reg == rf.read_reg2)) rd2 = rf.write_data;
        if (ZERO_REG && (rf.read_reg2 == '0))         rd2 = '0;
    end

    assign rf.read_data1 = rd1;
    assign rf.read_data2 = rd2;
    assign rf.clr_busy   = clr_busy;
    assign rf.clr_done   = clr_done;
endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: four configurations share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_register_file_param;

    localparam int NI = 4;
    // Instance 0: default; 1: no bypass; 2: 8 entries; 3: zero register with bypass.
    localparam int AW [NI] = '{2, 2, 3, 2};
    localparam int ZR [NI] = '{0, 0, 0, 1};
    localparam int BP [NI] = '{1, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       clr;

    logic [NI-1:0][7:0] rd1;
    logic [NI-1:0][7:0] rd2;
    logic [NI-1:0]      busy;
    logic [NI-1:0]      done;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        register_file_param_if #(.DATA_W(8), .ADDR_W(AW[g])) bus ();
        assign bus.reg_write  = we;
        assign bus.write_reg  = wa[AW[g]-1:0];
        assign bus.write_data = wd;
        assign bus.read_reg1  = ra1[AW[g]-1:0];
        assign bus.read_reg2  = ra2[AW[g]-1:0];
        assign bus.clr_req    = clr;
        assign rd1[g]  = bus.read_data1;
        assign rd2[g]  = bus.read_data2;
        assign busy[g] = bus.clr_busy;
        assign done[g] = bus.clr_done;

        register_file_param #(
            .DATA_W(8), .ADDR_W(AW[g]), .ZERO_REG(ZR[g] != 0), .BYPASS(BP[g] != 0)
        ) dut (
            .clk   (clk),
            .reset (rst),
            .rf    (bus)
        );
    end

    // Behavioural model: contents per instance plus how many clear steps remain.
    logic [7:0] m_mem  [NI][8];
    int         m_left [NI];
    bit         mvalid = 1'b0;
    int         n_chk  = 0;
    int         n_err  = 0;

    function automatic int depth_of(input int g);
        return 1 << AW[g];
    endfunction

    function automatic logic [7:0] m_rd(input int g, input logic [2:0] a);
        int ai, wi;
        ai = int'(a) % depth_of(g);
        wi = int'(wa) % depth_of(g);
        if (ZR[g] != 0 && ai == 0) return 8'h00;
        if (BP[g] != 0 && we && m_left[g] == 0 && wi == ai) return wd;
        return m_mem[g][ai];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
            int d, wi;
            d  = depth_of(g);
            wi = int'(wa) % d;
            if (rst) begin
                for (int i = 0; i < 8; i++) m_mem[g][i] = 8'h00;
                m_left[g] = 0;
            end else if (m_left[g] > 0) begin
                m_mem[g][d - m_left[g]] = 8'h00;
                m_left[g] = m_left[g] - 1;
            end else begin
                if (we && !(ZR[g] != 0 && wi == 0)) m_mem[g][wi] = wd;
                if (clr) m_left[g] = d;
            end
        end
        if (rst) mvalid = 1'b1;
    endtask

    // Apply one cycle's inputs and check every instance against the model.
    task automatic drive(input logic w, input logic [2:0] a, input logic [7:0] d,
                         input logic [2:0] r1, input logic [2:0] r2,
                         input logic c, input logic r);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; clr = c; rst = r;
        #1;
        if (mvalid) begin
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("i%0d rd1", g), 32'(rd1[g]), 32'(m_rd(g, ra1)));
                chk($sformatf("i%0d rd2", g), 32'(rd2[g]), 32'(m_rd(g, ra2)));
                chk($sformatf("i%0d busy", g), 32'(busy[g]), 32'(m_left[g] > 0));
                chk($sformatf("i%0d done", g), 32'(done[g]), 32'(m_left[g] == 1));
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int nb, nd;
        for (int g = 0; g < NI; g++) m_left[g] = 0;
        we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0; clr = 0; rst = 1;
        @(negedge clk);

        // Reset, then every address reads zero with the sequencer idle.
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        for (int a = 0; a < 8; a += 2) begin
            drive(0, 0, 0, 3'(a), 3'(a + 1), 0, 0);
            chk("reset rd1", 32'(rd1[2]), 32'h00);
            chk("reset rd2", 32'(rd2[2]), 32'h00);
            tick();
        end
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);

        // Write then read back; same-cycle bypass versus old value.
        drive(1, 3, 8'h5A, 0, 0, 0, 0); tick();
        drive(1, 2, 8'hA5, 0, 0, 0, 0); tick();
        drive(1, 3, 8'h3C, 2, 3, 0, 0);
        chk("wr r2 readback", 32'(rd1[0]), 32'hA5);
        chk("bypass on r3",   32'(rd2[0]), 32'h3C);
        chk("no bypass r3",   32'(rd2[1]), 32'h5A);
        tick();
        drive(0, 0, 0, 0, 3, 0, 0);
        chk("no bypass r3 next", 32'(rd2[1]), 32'h3C);
        tick();

        // Hard-wired zero register, including its bypass path.
        drive(1, 0, 8'hFF, 0, 0, 0, 0);
        chk("zero bypass", 32'(rd1[3]), 32'h00);
        chk("r0 bypass normal", 32'(rd1[0]), 32'hFF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("zero after wr", 32'(rd1[3]), 32'h00);
        tick();

        // Preload and clear a 4-entry file.
        drive(1, 0, 8'h11, 0, 0, 0, 0); tick();
        drive(1, 1, 8'h22, 0, 0, 0, 0); tick();
        drive(1, 2, 8'h33, 0, 0, 0, 0); tick();
        drive(1, 3, 8'h44, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("clr c1 busy", 32'(busy[0]), 32'h1);
        chk("clr c1 done", 32'(done[0]), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("clr c2 busy", 32'(busy[0]), 32'h1);
        tick();
        drive(1, 3, 8'h77, 0, 2, 1, 0);
        chk("clr c3 r0", 32'(rd1[0]), 32'h00);
        chk("clr c3 r2", 32'(rd2[0]), 32'h33);
        chk("clr c3 done", 32'(done[0]), 32'h0);
        tick();
        drive(0, 0, 0, 1, 3, 0, 0);
        chk("clr c4 r1", 32'(rd1[0]), 32'h00);
        chk("clr c4 r3 kept", 32'(rd2[0]), 32'h44);
        chk("clr c4 done", 32'(done[0]), 32'h1);
        tick();
        drive(0, 0, 0, 0, 3, 0, 0);
        chk("clr end busy", 32'(busy[0]), 32'h0);
        chk("clr end r3", 32'(rd2[0]), 32'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0); tick();
        end

        // 8-entry file: reset during the third clear cycle, then held request.
        drive(1, 7, 8'h99, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 7, 0, 0, 1);
        chk("mid-clr rst done", 32'(done[2]), 32'h0);
        tick();
        nb = 0; nd = 0;
        for (int i = 0; i < 18; i++) begin
            drive(0, 0, 0, 7, 5, 1, 0);
            if (i == 0) begin
                chk("post rst busy", 32'(busy[2]), 32'h0);
                chk("post rst done", 32'(done[2]), 32'h0);
                chk("post rst r7", 32'(rd1[2]), 32'h00);
            end
            if (i == 9) chk("gap idle", 32'(busy[2]), 32'h0);
            nb += int'(busy[2]);
            nd += int'(done[2]);
            tick();
        end
        chk("b2b busy cycles", 32'(nb), 32'd16);
        chk("b2b done pulses", 32'(nd), 32'd2);
        drive(0, 0, 0, 0, 0, 0, 0); tick();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom),
                  3'($urandom), 3'($urandom),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 59) == 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
